// File: rtl/mux_rr_sched_pkg.sv
// Shared definitions for the round-robin 4:1 scheduler.
//   state_t : scheduler state (IDLE = no grant, BUSY = grant held)
//   NREQ    : number of requesters
//   SELW    : width of the select index
//   onehot  : select index to one-hot grant vector
package mux_rr_sched_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned SELW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_sched_if.sv
// Bus between the four producers / one consumer and the scheduler.
//   d0..d3  : source data, one per requester
//   req     : per-requester request, level-held while data is pending
//   ack     : consumer accepts the current beat
//   grant   : one-hot grant (0 when idle)
//   sel     : index of the granted requester
//   o       : selected data, 0 when not valid
//   o_valid : a grant is held
// master = producers/consumer side, slave = scheduler side.
interface mux_rr_sched_if #(
  parameter int unsigned W = 4
);

  logic [W-1:0]                          d0;
  logic [W-1:0]                          d1;
  logic [W-1:0]                          d2;
  logic [W-1:0]                          d3;
  logic [mux_rr_sched_pkg::NREQ-1:0]     req;
  logic                                  ack;
  logic [mux_rr_sched_pkg::NREQ-1:0]     grant;
  logic [mux_rr_sched_pkg::SELW-1:0]     sel;
  logic [W-1:0]                          o;
  logic                                  o_valid;

  modport master (
    output d0, d1, d2, d3, req, ack,
    input  grant, sel, o, o_valid
  );

  modport slave (
    input  d0, d1, d2, d3, req, ack,
    output grant, sel, o, o_valid
  );

endinterface

// File: rtl/mux_rr_sched_rr_pick4.sv
// Combinational rotate-priority picker.
//   req : request vector
//   ptr : highest-priority position for this pick
//   idx : first set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   any : at least one request is set (idx is 0 otherwise)
module rr_pick4
  import mux_rr_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [SELW-1:0] pos;

  // Walk from lowest priority to highest so the last hit is the winner.
  always_comb begin
    idx = '0;
    pos = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      pos = ptr + SELW'(k - 1);
      if (req[pos]) idx = pos;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one 4:1 data select path between four
// requesters. A registered one-hot grant and 2-bit select steer the granted
// source onto o; each tenure is bounded to MAX_HOLD accepted beats, after
// which the grant rotates.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : scheduler side of mux_rr_sched_if (d0..d3, req, ack in;
//           grant, sel, o, o_valid out)
module mux_rr_sched
  import mux_rr_sched_pkg::*;
#(
  parameter int unsigned w        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_sched_if.slave  bus
);

  localparam int unsigned CW   = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  state_t          state, state_n;
  logic [NREQ-1:0] grant, grant_n;
  logic [SELW-1:0] sel, sel_n;
  logic [SELW-1:0] ptr, ptr_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic [SELW-1:0] pick_ptr;
  logic [SELW-1:0] pick_idx;
  logic            pick_any;
  logic            release_now;
  logic [w-1:0]    data_mux;

  // While busy the only pick that matters is the re-pick on release, which
  // must already use the rotated pointer sel+1; in IDLE ptr holds that value.
  assign pick_ptr = (state == BUSY) ? sel + SELW'(1) : ptr;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign release_now = !bus.req[sel] || (bus.ack && (cnt == LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = BUSY;
          sel_n   = pick_idx;
          grant_n = onehot(pick_idx);
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_n = sel + SELW'(1);
          cnt_n = '0;
          // Back-to-back handover: re-pick in the same edge, no idle bubble.
          if (pick_any) begin
            sel_n   = pick_idx;
            grant_n = onehot(pick_idx);
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end else if (bus.ack) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_comb begin
    data_mux = '0;
    case (sel)
      2'd1:    data_mux = bus.d1;
      2'd2:    data_mux = bus.d2;
      2'd3:    data_mux = bus.d3;
      default: data_mux = bus.d0;
    endcase
  end

  assign bus.grant   = grant;
  assign bus.sel     = sel;
  assign bus.o_valid = (state == BUSY);
  assign bus.o       = (state == BUSY) ? data_mux : '0;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Testbench for mux_rr_sched: two instances (MAX_HOLD=8 and MAX_HOLD=2)
// share the same stimulus; a behavioural model tracks owner/beats/pointer
// and is compared every cycle, with directed literal checks on top.
module tb_mux_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'h0;
  logic       ack = 1'b0;
  logic [3:0] d [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_rr_sched_if #(.W(4)) bus_a ();
  mux_rr_sched_if #(.W(4)) bus_b ();

  assign bus_a.req = req;
  assign bus_a.ack = ack;
  assign bus_a.d0  = d[0];
  assign bus_a.d1  = d[1];
  assign bus_a.d2  = d[2];
  assign bus_a.d3  = d[3];
  assign bus_b.req = req;
  assign bus_b.ack = ack;
  assign bus_b.d0  = d[0];
  assign bus_b.d1  = d[1];
  assign bus_b.d2  = d[2];
  assign bus_b.d3  = d[3];

  mux_rr_sched #(.w(4), .MAX_HOLD(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_rr_sched #(.w(4), .MAX_HOLD(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [3:0] g_o [2];
  logic [3:0] o_o [2];
  logic [1:0] s_o [2];
  logic       v_o [2];
  assign g_o[0] = bus_a.grant;
  assign g_o[1] = bus_b.grant;
  assign o_o[0] = bus_a.o;
  assign o_o[1] = bus_b.o;
  assign s_o[0] = bus_a.sel;
  assign s_o[1] = bus_b.sel;
  assign v_o[0] = bus_a.o_valid;
  assign v_o[1] = bus_b.o_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner (-1 = none), beats accepted, rotation start.
  int m_own [2];
  int m_cnt [2];
  int m_ptr [2];
  int hold  [2];
  initial begin
    hold[0] = 8;
    hold[1] = 2;
  end

  function automatic int pick(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_own[i] <= -1;
        m_cnt[i] <= 0;
        m_ptr[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int own, c, pt;
        own = m_own[i];
        c   = m_cnt[i];
        pt  = m_ptr[i];
        if (own < 0) begin
          own = pick(pt, req);
          c   = 0;
        end else if (!req[own] || (ack && (c + 1 == hold[i]))) begin
          pt  = (own + 1) % 4;
          own = pick(pt, req);
          c   = 0;
        end else if (ack) begin
          c = c + 1;
        end
        m_own[i] <= own;
        m_cnt[i] <= c;
        m_ptr[i] <= pt;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (m_own[i] >= 0) begin
          chk("model_grant", 32'(g_o[i]), 32'(4'b0001 << m_own[i]));
          chk("model_sel",   32'(s_o[i]), 32'(m_own[i]));
          chk("model_valid", 32'(v_o[i]), 32'd1);
          chk("model_o",     32'(o_o[i]), 32'(d[m_own[i]]));
        end else begin
          chk("model_grant", 32'(g_o[i]), 32'd0);
          chk("model_valid", 32'(v_o[i]), 32'd0);
          chk("model_o",     32'(o_o[i]), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'h0;
    ack   = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] fair [9];
  int held;

  initial begin
    d[0] = 4'h3; d[1] = 4'hA; d[2] = 4'h5; d[3] = 4'hC;
    fair[0] = 4'b0001; fair[1] = 4'b0001; fair[2] = 4'b0010;
    fair[3] = 4'b0010; fair[4] = 4'b0100; fair[5] = 4'b0100;
    fair[6] = 4'b1000; fair[7] = 4'b1000; fair[8] = 4'b0001;

    // 1 reset with all requests asserted
    #2;
    rst_n = 1'b0;
    req   = 4'hF;
    tick();
    chk("reset_grant", 32'(bus_a.grant),   32'd0);
    chk("reset_sel",   32'(bus_a.sel),     32'd0);
    chk("reset_valid", 32'(bus_a.o_valid), 32'd0);
    chk("reset_o",     32'(bus_a.o),       32'd0);
    req   = 4'h0;
    rst_n = 1'b1;
    tick();

    // 2 single requester
    req = 4'b0010;
    ack = 1'b1;
    tick();
    chk("single_grant", 32'(bus_a.grant), 32'b0010);
    chk("single_o0",    32'(bus_a.o),     32'hA);
    tick();
    chk("single_o1",    32'(bus_a.o),     32'hA);
    tick();
    chk("single_o2",    32'(bus_a.o),     32'hA);
    req = 4'b0000;
    tick();
    chk("single_idle",  32'(bus_a.grant),   32'd0);
    chk("single_nv",    32'(bus_a.o_valid), 32'd0);
    req = 4'b0011;
    ack = 1'b0;
    tick();
    chk("single_ptr2",  32'(bus_a.grant), 32'b0001);

    // 3 fairness on the MAX_HOLD=2 instance
    do_reset();
    req = 4'hF;
    ack = 1'b1;
    for (int n = 0; n < 9; n++) begin
      tick();
      chk("fair_grant", 32'(bus_b.grant), 32'(fair[n]));
    end

    // 4 stall, then release after MAX_HOLD accepted beats
    do_reset();
    req = 4'b0011;
    ack = 1'b0;
    tick();
    chk("stall_grant0", 32'(bus_a.grant), 32'b0001);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("stall_grant", 32'(bus_a.grant), 32'b0001);
      chk("stall_o",     32'(bus_a.o),     32'h3);
    end
    ack  = 1'b1;
    held = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus_a.grant != 4'b0001) break;
      held++;
    end
    chk("stall_held", 32'(held), 32'd7);
    chk("stall_next", 32'(bus_a.grant), 32'b0010);

    // 5 withdraw without ack hands over on the next edge
    do_reset();
    req = 4'b0100;
    ack = 1'b0;
    tick();
    chk("wd_grant2", 32'(bus_a.grant), 32'b0100);
    req = 4'b1000;
    tick();
    chk("wd_grant3", 32'(bus_a.grant), 32'b1000);

    // 6 async reset between edges, pointer returns to 0
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_grant", 32'(bus_a.grant),   32'd0);
    chk("areset_sel",   32'(bus_a.sel),     32'd0);
    chk("areset_valid", 32'(bus_a.o_valid), 32'd0);
    chk("areset_o",     32'(bus_a.o),       32'd0);
    req = 4'b1100;
    tick();
    rst_n = 1'b1;
    tick();
    chk("areset_ptr0",  32'(bus_a.grant), 32'b0100);

    req = 4'h0;
    ack = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
